// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing blocks: standard mode timings,
// the per-pixel control word carried down the sync delay line, and clog2.
package video_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_front_porch;
      int h_sync;
      int h_back_porch;
      int v_active;
      int v_front_porch;
      int v_sync;
      int v_back_porch;
      int hsync_pol;
      int vsync_pol;
   } video_timing_t;

   // 640x480@60, 25.175 MHz pixel clock, negative syncs.
   localparam video_timing_t VGA_640X480 = '{
      h_active: 640, h_front_porch: 16, h_sync: 96,  h_back_porch: 48,
      v_active: 480, v_front_porch: 10, v_sync: 2,   v_back_porch: 33,
      hsync_pol: 0,  vsync_pol: 0
   };

   // 800x600@60, 40 MHz pixel clock, positive syncs.
   localparam video_timing_t SVGA_800X600 = '{
      h_active: 800, h_front_porch: 40, h_sync: 128, h_back_porch: 88,
      v_active: 600, v_front_porch: 1,  v_sync: 4,   v_back_porch: 23,
      hsync_pol: 1,  vsync_pol: 1
   };

   // Raw (polarity-free) per-pixel controls, travelling with the upstream pipeline.
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } pix_ctl_t;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/pixel_en_div.sv
// Pixel-enable divider: one pe pulse every CLK_DIV clocks while enabled,
// synchronously parked at count 0 when enable is low.
module pixel_en_div
   import video_timing_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic pe
);

   localparam int               DIV_W    = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;

   // Next count: 0..CLK_DIV-1 while running, back to 0 when disabled.
   always_comb begin
      // NOTE: default assigned before any branch so no path leaves div_d unassigned (no latch).
      div_d = '0;
      if (enable && (div_q != DIV_LAST)) div_d = div_q + 1'b1;
   end

   // Divider state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all flop updates so every register samples pre-edge values.
      if (!rst_n) div_q <= '0;
      else        div_q <= div_d;
   end

   assign pe = enable && (div_q == DIV_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pipeline-compensated sync/RGB output stage.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int  H_ACTIVE      = VGA_640X480.h_active,
   parameter int  H_FRONT_PORCH = VGA_640X480.h_front_porch,
   parameter int  H_SYNC        = VGA_640X480.h_sync,
   parameter int  H_BACK_PORCH  = VGA_640X480.h_back_porch,
   parameter int  V_ACTIVE      = VGA_640X480.v_active,
   parameter int  V_FRONT_PORCH = VGA_640X480.v_front_porch,
   parameter int  V_SYNC        = VGA_640X480.v_sync,
   parameter int  V_BACK_PORCH  = VGA_640X480.v_back_porch,
   parameter int  CLK_DIV       = 2,
   parameter int  COLOR_W       = 4,
   parameter int  HSYNC_POL     = VGA_640X480.hsync_pol,
   parameter int  VSYNC_POL     = VGA_640X480.vsync_pol,
   parameter int  PIPE_DLY      = 2,
   parameter int  EARLY_LINES   = 1,
   localparam int H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
   localparam int V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
   localparam int X_W           = clog2(H_TOTAL),
   localparam int Y_W           = clog2(V_TOTAL)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [3*COLOR_W-1:0] palette_rgb_data,
   input  logic [Y_W-1:0]       line_irq_cmp,
   output logic                 next_frame,
   output logic                 next_line,
   output logic                 next_pixel,
   output logic                 vblank_pulse,
   output logic                 line_irq_pulse,
   output logic [X_W-1:0]       x_pos,
   output logic [Y_W-1:0]       y_pos,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 vga_hsync,
   output logic                 vga_vsync
);

   // Counter landmarks, all expressed as inclusive bounds so none overflows the counter width.
   localparam logic [X_W-1:0] X_LAST      = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] X_ACT_LAST  = X_W'(H_ACTIVE - 1);
   localparam logic [X_W-1:0] HS_FIRST    = X_W'(H_ACTIVE + H_FRONT_PORCH);
   localparam logic [X_W-1:0] HS_LAST     = X_W'(H_ACTIVE + H_FRONT_PORCH + H_SYNC - 1);
   localparam logic [Y_W-1:0] Y_LAST      = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_ACT_LAST  = Y_W'(V_ACTIVE - 1);
   localparam logic [Y_W-1:0] VS_FIRST    = Y_W'(V_ACTIVE + V_FRONT_PORCH);
   localparam logic [Y_W-1:0] VS_LAST     = Y_W'(V_ACTIVE + V_FRONT_PORCH + V_SYNC - 1);
   localparam logic [Y_W-1:0] Y_FRAME_REQ = Y_W'(V_TOTAL - 1 - EARLY_LINES);
   localparam logic           HS_ON       = 1'(HSYNC_POL);
   localparam logic           VS_ON       = 1'(VSYNC_POL);

   logic                 pe, h_last, v_last;
   logic [Y_W-1:0]       ny;
   logic [X_W-1:0]       x_q, x_d;
   logic [Y_W-1:0]       y_q, y_d;
   pix_ctl_t             raw;
   pix_ctl_t             dly_q [PIPE_DLY];
   pix_ctl_t             dly_d [PIPE_DLY];
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;
   logic                 hsync_q, hsync_d, vsync_q, vsync_d;

   pixel_en_div #(.CLK_DIV(CLK_DIV)) u_pixel_en_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .pe     (pe)
   );

   assign h_last = (x_q == X_LAST);
   assign v_last = (y_q == Y_LAST);
   assign ny     = v_last ? '0 : y_q + 1'b1;

   // Strobes are decoded straight from pe and the current counters.
   assign next_pixel     = pe;
   assign next_line      = pe && h_last;
   assign next_frame     = next_line && (y_q == Y_FRAME_REQ);
   assign vblank_pulse   = next_line && (y_q == Y_ACT_LAST);
   assign line_irq_pulse = next_line && (ny == line_irq_cmp);

   assign raw.hs  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
   assign raw.vs  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
   assign raw.act = (x_q <= X_ACT_LAST) && (y_q <= Y_ACT_LAST);

   // Raster counters: x wraps every line, y steps at line end and wraps every frame.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (!enable) begin
         x_d = '0;
         y_d = '0;
      end else if (pe) begin
         x_d = h_last ? '0 : x_q + 1'b1;
         if (h_last) y_d = ny;
      end
   end

   // Delay line aligns sync/active with the upstream pixel pipeline; output stage applies polarity and blanking.
   always_comb begin
      dly_d   = dly_q;
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      if (!enable) begin
         dly_d   = '{default: '0};
         rgb_d   = '0;
         hsync_d = ~HS_ON;
         vsync_d = ~VS_ON;
      end else if (pe) begin
         dly_d[0] = raw;
         for (int i = 1; i < PIPE_DLY; i++) dly_d[i] = dly_q[i-1];
         rgb_d   = dly_q[PIPE_DLY-1].act ? palette_rgb_data : '0;
         hsync_d = dly_q[PIPE_DLY-1].hs ~^ HS_ON;
         vsync_d = dly_q[PIPE_DLY-1].vs ~^ VS_ON;
      end
   end

   // All timing and output state; async reset to the idle raster with syncs inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         // NOTE: the delay line is a few flops, not a RAM, so it is reset with everything else.
         dly_q   <= '{default: '0};
         rgb_q   <= '0;
         hsync_q <= ~HS_ON;
         vsync_q <= ~VS_ON;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         dly_q   <= dly_d;
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign x_pos     = x_q;
   assign y_pos     = y_q;
   assign vga_r     = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign vga_g     = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign vga_b     = rgb_q[COLOR_W-1:0];
   assign vga_hsync = hsync_q;
   assign vga_vsync = vsync_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small-raster instances (divided pixel clock with
// negative syncs, and undivided clock with positive syncs and 24-bit colour) driven
// with random enable drops, palette data, line-compare values and one async reset,
// compared every clock against an arithmetic raster model.
module tb_video_timing_gen;

   typedef struct packed {
      int h_act, h_fp, h_sync, h_bp;
      int v_act, v_fp, v_sync, v_bp;
      int div, pipe, early, hpol, vpol, cw;
   } cfg_t;

   typedef struct {
      logic [31:0] pix, line, frame, vbl, irq, x, y, r, g, b, hs, vs;
   } obs_t;

   localparam cfg_t CFG_A = '{h_act: 16, h_fp: 4, h_sync: 6, h_bp: 4,
                              v_act: 10, v_fp: 2, v_sync: 3, v_bp: 3,
                              div: 2, pipe: 2, early: 1, hpol: 0, vpol: 0, cw: 4};
   localparam cfg_t CFG_B = '{h_act: 12, h_fp: 3, h_sync: 5, h_bp: 2,
                              v_act: 6, v_fp: 1, v_sync: 2, v_bp: 2,
                              div: 1, pipe: 3, early: 2, hpol: 1, vpol: 1, cw: 8};

   logic        clk = 1'b0;
   logic        rst_n, enable;
   logic [11:0] a_pal;
   logic [23:0] b_pal;
   logic [4:0]  a_cmp;
   logic [3:0]  b_cmp;

   logic       a_frame, a_line, a_pix, a_vbl, a_irq, a_hs, a_vs;
   logic [4:0] a_x, a_y;
   logic [3:0] a_r, a_g, a_b;
   logic       b_frame, b_line, b_pix, b_vbl, b_irq, b_hs, b_vs;
   logic [4:0] b_x;
   logic [3:0] b_y;
   logic [7:0] b_r, b_g, b_b;

   int n_vec = 0;
   int n_err = 0;
   int n_a, n_b;           // clocks run since the last clear, per instance
   int pal_last_a, pal_last_b;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(CFG_A.h_act), .H_FRONT_PORCH(CFG_A.h_fp), .H_SYNC(CFG_A.h_sync), .H_BACK_PORCH(CFG_A.h_bp),
      .V_ACTIVE(CFG_A.v_act), .V_FRONT_PORCH(CFG_A.v_fp), .V_SYNC(CFG_A.v_sync), .V_BACK_PORCH(CFG_A.v_bp),
      .CLK_DIV(CFG_A.div), .COLOR_W(CFG_A.cw), .HSYNC_POL(CFG_A.hpol), .VSYNC_POL(CFG_A.vpol),
      .PIPE_DLY(CFG_A.pipe), .EARLY_LINES(CFG_A.early)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .palette_rgb_data(a_pal), .line_irq_cmp(a_cmp),
      .next_frame(a_frame), .next_line(a_line), .next_pixel(a_pix), .vblank_pulse(a_vbl),
      .line_irq_pulse(a_irq), .x_pos(a_x), .y_pos(a_y), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
      .vga_hsync(a_hs), .vga_vsync(a_vs)
   );

   video_timing_gen #(
      .H_ACTIVE(CFG_B.h_act), .H_FRONT_PORCH(CFG_B.h_fp), .H_SYNC(CFG_B.h_sync), .H_BACK_PORCH(CFG_B.h_bp),
      .V_ACTIVE(CFG_B.v_act), .V_FRONT_PORCH(CFG_B.v_fp), .V_SYNC(CFG_B.v_sync), .V_BACK_PORCH(CFG_B.v_bp),
      .CLK_DIV(CFG_B.div), .COLOR_W(CFG_B.cw), .HSYNC_POL(CFG_B.hpol), .VSYNC_POL(CFG_B.vpol),
      .PIPE_DLY(CFG_B.pipe), .EARLY_LINES(CFG_B.early)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .palette_rgb_data(b_pal), .line_irq_cmp(b_cmp),
      .next_frame(b_frame), .next_line(b_line), .next_pixel(b_pix), .vblank_pulse(b_vbl),
      .line_irq_pulse(b_irq), .x_pos(b_x), .y_pos(b_y), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
      .vga_hsync(b_hs), .vga_vsync(b_vs)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected raster state after n clocks of running: pixel index p = n / div; pins
   // show pixel p-1-pipe (pipeline plus output register), blank/inactive before that.
   function automatic obs_t model(input cfg_t c, input int n, input bit en, input int cmp, input int pal);
      obs_t o;
      int ht, vt, p, k, xk, yk, mask;
      bit pe, eol;
      ht   = c.h_act + c.h_fp + c.h_sync + c.h_bp;
      vt   = c.v_act + c.v_fp + c.v_sync + c.v_bp;
      mask = (1 << c.cw) - 1;
      pe   = en && ((n % c.div) == c.div - 1);
      p    = n / c.div;
      o.x  = p % ht;
      o.y  = (p / ht) % vt;
      eol  = pe && (o.x == ht - 1);
      o.pix   = pe ? 1 : 0;
      o.line  = eol ? 1 : 0;
      o.frame = (eol && o.y == vt - 1 - c.early) ? 1 : 0;
      o.vbl   = (eol && o.y == c.v_act - 1) ? 1 : 0;
      o.irq   = (eol && ((o.y + 1) % vt) == cmp) ? 1 : 0;
      o.hs = (c.hpol != 0) ? 0 : 1;
      o.vs = (c.vpol != 0) ? 0 : 1;
      o.r = 0; o.g = 0; o.b = 0;
      k = p - 1 - c.pipe;
      if (k >= 0) begin
         xk = k % ht;
         yk = (k / ht) % vt;
         if (xk >= c.h_act + c.h_fp && xk < c.h_act + c.h_fp + c.h_sync) o.hs = c.hpol;
         if (yk >= c.v_act + c.v_fp && yk < c.v_act + c.v_fp + c.v_sync) o.vs = c.vpol;
         if (xk < c.h_act && yk < c.v_act) begin
            o.r = (pal >> (2 * c.cw)) & mask;
            o.g = (pal >> c.cw) & mask;
            o.b = pal & mask;
         end
      end
      return o;
   endfunction

   task automatic check_regs(input string inst, input obs_t act, input obs_t exp);
      check({inst, ".x_pos"},     act.x,  exp.x);
      check({inst, ".y_pos"},     act.y,  exp.y);
      check({inst, ".vga_r"},     act.r,  exp.r);
      check({inst, ".vga_g"},     act.g,  exp.g);
      check({inst, ".vga_b"},     act.b,  exp.b);
      check({inst, ".vga_hsync"}, act.hs, exp.hs);
      check({inst, ".vga_vsync"}, act.vs, exp.vs);
   endtask

   task automatic check_all(input string inst, input obs_t act, input obs_t exp);
      check({inst, ".next_pixel"},     act.pix,   exp.pix);
      check({inst, ".next_line"},      act.line,  exp.line);
      check({inst, ".next_frame"},     act.frame, exp.frame);
      check({inst, ".vblank_pulse"},   act.vbl,   exp.vbl);
      check({inst, ".line_irq_pulse"}, act.irq,   exp.irq);
      check_regs(inst, act, exp);
   endtask

   function automatic obs_t grab_a();
      obs_t o;
      o.pix = 32'(a_pix); o.line = 32'(a_line); o.frame = 32'(a_frame); o.vbl = 32'(a_vbl);
      o.irq = 32'(a_irq); o.x = 32'(a_x); o.y = 32'(a_y); o.r = 32'(a_r); o.g = 32'(a_g);
      o.b = 32'(a_b); o.hs = 32'(a_hs); o.vs = 32'(a_vs);
      return o;
   endfunction

   function automatic obs_t grab_b();
      obs_t o;
      o.pix = 32'(b_pix); o.line = 32'(b_line); o.frame = 32'(b_frame); o.vbl = 32'(b_vbl);
      o.irq = 32'(b_irq); o.x = 32'(b_x); o.y = 32'(b_y); o.r = 32'(b_r); o.g = 32'(b_g);
      o.b = 32'(b_b); o.hs = 32'(b_hs); o.vs = 32'(b_vs);
      return o;
   endfunction

   task automatic compare_both();
      check_all("A", grab_a(), model(CFG_A, n_a, enable, int'(a_cmp), pal_last_a));
      check_all("B", grab_b(), model(CFG_B, n_b, enable, int'(b_cmp), pal_last_b));
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      if (!rst_n || !enable) begin
         n_a = 0;
         n_b = 0;
      end else begin
         if ((n_a % CFG_A.div) == CFG_A.div - 1) pal_last_a = int'(a_pal);
         if ((n_b % CFG_B.div) == CFG_B.div - 1) pal_last_b = int'(b_pal);
         n_a++;
         n_b++;
      end
   endtask

   initial begin
      int hold;
      rst_n = 1'b0; enable = 1'b0;
      a_pal = 12'hABC; b_pal = 24'h123456; a_cmp = 5'd0; b_cmp = 4'd0;
      n_a = 0; n_b = 0; pal_last_a = 0; pal_last_b = 0; hold = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      compare_both();                       // reset state

      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(posedge clk);
         model_step();
         #1;
         a_pal = 12'($urandom);
         b_pal = 24'($urandom);
         if ($urandom_range(0, 63) == 0) begin
            a_cmp = 5'($urandom_range(0, 20));   // values >= 18 must never fire
            b_cmp = 4'($urandom_range(0, 13));   // values >= 11 must never fire
         end
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if (!enable) begin
            if (hold == 0) enable = 1'b1;
            else hold--;
         end else if (cyc == 2000 || $urandom_range(0, 799) == 0) begin
            enable = 1'b0;
            hold   = $urandom_range(0, 4);
         end

         if (cyc == 3500) begin
            // Asynchronous reset mid-line: registered outputs clear with no clock edge.
            rst_n  = 1'b0;
            enable = 1'b0;
            n_a    = 0;
            n_b    = 0;
            #1;
            check_regs("A.async_rst", grab_a(), model(CFG_A, 0, 1'b0, int'(a_cmp), 0));
            check_regs("B.async_rst", grab_b(), model(CFG_B, 0, 1'b0, int'(b_cmp), 0));
         end

         @(negedge clk);
         compare_both();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
